// File: rtl/alu_serial_seq_if.sv
// Handshake, operand and result bundle for alu_serial_seq.
// The master drives operands and controls; the slave returns result, flags and status.
interface alu_serial_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] opA;
    logic [WIDTH-1:0] opB;
    logic             invA;
    logic             enA;
    logic             enB;
    logic             f0;
    logic             f1;
    logic             cin;
    logic             sll8;
    logic             sra1;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             flagN;
    logic             flagZ;
    logic             busy;
    logic             done;

    modport master (
        output start, opA, opB, invA, enA, enB, f0, f1, cin, sll8, sra1,
        input  result, cout, flagN, flagZ, busy, done
    );

    modport slave (
        input  start, opA, opB, invA, enA, enB, f0, f1, cin, sll8, sra1,
        output result, cout, flagN, flagZ, busy, done
    );
endinterface

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: walks an external 1-bit ALU slice LSB-first over WIDTH cycles.
// Define ALU_SHIFT_EN to add a one-cycle post-shift stage (sll8 / sra1) after the serial pass.
module alu_serial_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_serial_seq_if.slave   bus,
    output logic              sliceA,
    output logic              sliceB,
    output logic              sliceCarryIn,
    output logic              sliceInvA,
    output logic              sliceEnA,
    output logic              sliceEnB,
    output logic              sliceF0,
    output logic              sliceF1,
    input  logic              sliceOut,
    input  logic              sliceCarryOut
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] shifted;
    logic             inv_q, ena_q, enb_q, f0_q, f1_q, cin_q, sll8_q, sra1_q;
    logic             carry_q, cout_q, n_q, z_q, busy_q, done_q;
    logic             running;

    // Slice drives decode straight from registered state so they are zero outside RUN.
    assign running      = (state == RUN);
    assign sliceA       = running & a_q[cnt];
    assign sliceB       = running & b_q[cnt];
    assign sliceCarryIn = running & ((cnt == '0) ? cin_q : carry_q);
    assign sliceInvA    = running & inv_q;
    assign sliceEnA     = running & ena_q;
    assign sliceEnB     = running & enb_q;
    assign sliceF0      = running & f0_q;
    assign sliceF1      = running & f1_q;

    always_comb begin
        shifted = res_q;
        if (sll8_q)
            shifted = res_q << 8;
        else if (sra1_q)
            shifted = {res_q[WIDTH-1], res_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cout_q  <= 1'b0;
            n_q     <= 1'b0;
            z_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_q     <= bus.opA;
                        b_q     <= bus.opB;
                        inv_q   <= bus.invA;
                        ena_q   <= bus.enA;
                        enb_q   <= bus.enB;
                        f0_q    <= bus.f0;
                        f1_q    <= bus.f1;
                        cin_q   <= bus.cin;
                        sll8_q  <= bus.sll8;
                        sra1_q  <= bus.sra1;
                        cnt     <= '0;
                        carry_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res_q[cnt] <= sliceOut;
                    carry_q    <= sliceCarryOut;
                    if (cnt == LAST) begin
                        cout_q <= sliceCarryOut;
`ifdef ALU_SHIFT_EN
                        state  <= SHIFT;
`else
                        busy_q <= 1'b0;
                        state  <= DONE;
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    res_q  <= shifted;
                    busy_q <= 1'b0;
                    state  <= DONE;
                end
                DONE: begin
                    done_q <= 1'b1;
                    n_q    <= res_q[WIDTH-1];
                    z_q    <= (res_q == '0);
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.result = res_q;
    assign bus.cout   = cout_q;
    assign bus.flagN  = n_q;
    assign bus.flagZ  = z_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed self-checking bench for alu_serial_seq (WIDTH=8) with a behavioural 1-bit ALU slice.
// Expected timing and shift results follow ALU_SHIFT_EN when it is defined.
module tb_alu_serial_seq;
    localparam int WIDTH = 8;
`ifdef ALU_SHIFT_EN
    localparam int LAT   = 10;
    localparam int BUSYC = 9;
`else
    localparam int LAT   = 9;
    localparam int BUSYC = 8;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_serial_seq_if #(.WIDTH(WIDTH)) bus ();

    logic sliceA, sliceB, sliceCarryIn, sliceInvA, sliceEnA, sliceEnB, sliceF0, sliceF1;
    logic sliceOut, sliceCarryOut;

    alu_serial_seq #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .sliceA       (sliceA),
        .sliceB       (sliceB),
        .sliceCarryIn (sliceCarryIn),
        .sliceInvA    (sliceInvA),
        .sliceEnA     (sliceEnA),
        .sliceEnB     (sliceEnB),
        .sliceF0      (sliceF0),
        .sliceF1      (sliceF1),
        .sliceOut     (sliceOut),
        .sliceCarryOut(sliceCarryOut)
    );

    // 1-bit slice: f1f0 = 00 AND, 01 OR, 10 NOT B, 11 full add
    logic sa, sb;
    always_comb begin
        sa            = sliceInvA ^ (sliceEnA & sliceA);
        sb            = sliceEnB & sliceB;
        sliceCarryOut = 1'b0;
        case ({sliceF1, sliceF0})
            2'b00:   sliceOut = sa & sb;
            2'b01:   sliceOut = sa | sb;
            2'b10:   sliceOut = ~sb;
            default: begin
                sliceOut      = sa ^ sb ^ sliceCarryIn;
                sliceCarryOut = (sa & sb) | (sliceCarryIn & (sa ^ sb));
            end
        endcase
    end

    int errors = 0;
    int checks = 0;
    int lat, bc, done_seen;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic inv,
                            input logic ea, input logic eb, input logic f1, input logic f0,
                            input logic ci, input logic s8, input logic s1);
        @(negedge clk);
        bus.opA  = a;
        bus.opB  = b;
        bus.invA = inv;
        bus.enA  = ea;
        bus.enB  = eb;
        bus.f1   = f1;
        bus.f0   = f0;
        bus.cin  = ci;
        bus.sll8 = s8;
        bus.sra1 = s1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Returns at the negedge where done is seen; lat counts cycles since acceptance.
    task automatic wait_done(input int poke_at, input bit slice_chk, output int l, output int b);
        l = 0;
        b = 0;
        while (bus.done !== 1'b1 && l < 40) begin
            if (bus.busy === 1'b1) b++;
            if (slice_chk && l == 0) begin
                chk("run0.sliceA", sliceA, 1'b1);
                chk("run0.sliceCarryIn", sliceCarryIn, 1'b0);
                chk("run0.ctrl", {sliceInvA, sliceEnA, sliceEnB, sliceF1, sliceF0}, 5'b01111);
            end
            if (slice_chk && l == 4) begin
                chk("run4.sliceA", sliceA, 1'b0);
                chk("run4.sliceCarryIn", sliceCarryIn, 1'b1);
            end
            if (l == poke_at) begin
                bus.start = 1'b1;
                bus.opA   = 8'hAA;
                bus.opB   = 8'h55;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            l++;
        end
        bus.start = 1'b0;
    endtask

    task automatic check_result(input string tag, input logic [7:0] r, input logic c,
                                input logic n, input logic z, input int l, input int b);
        chk({tag, ".latency"}, l, LAT);
        chk({tag, ".busycycles"}, b, BUSYC);
        chk({tag, ".result"}, bus.result, r);
        chk({tag, ".cout"}, bus.cout, c);
        chk({tag, ".flagN"}, bus.flagN, n);
        chk({tag, ".flagZ"}, bus.flagZ, z);
        chk({tag, ".drives_idle"},
            {sliceA, sliceB, sliceCarryIn, sliceInvA, sliceEnA, sliceEnB, sliceF0, sliceF1}, 8'h00);
        @(negedge clk);
        chk({tag, ".done_pulse"}, bus.done, 1'b0);
        chk({tag, ".held"}, bus.result, r);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.opA = '0; bus.opB = '0;
        bus.invA = 1'b0; bus.enA = 1'b0; bus.enB = 1'b0;
        bus.f0 = 1'b0; bus.f1 = 1'b0; bus.cin = 1'b0;
        bus.sll8 = 1'b0; bus.sra1 = 1'b0;

        // Reset state, and a start coincident with reset is dropped
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        chk("rst.result", bus.result, 8'h00);
        chk("rst.status", {bus.busy, bus.done, bus.cout, bus.flagN, bus.flagZ}, 5'b00000);
        chk("rst.drives", {sliceA, sliceB, sliceCarryIn, sliceInvA, sliceEnA, sliceEnB, sliceF0, sliceF1}, 8'h00);
        rst_n = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        chk("rst.start_dropped", bus.busy, 1'b0);

        // 0x0F + 0x01
        start_op(8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(-1, 1'b1, lat, bc);
        check_result("add0f01", 8'h10, 1'b0, 1'b0, 1'b0, lat, bc);

        // 0xFF + 0x01 wraps to zero with carry; flags hold while idle
        start_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(-1, 1'b0, lat, bc);
        check_result("addff01", 8'h00, 1'b1, 1'b0, 1'b1, lat, bc);
        repeat (5) @(negedge clk);
        chk("idlehold.flags", {bus.cout, bus.flagN, bus.flagZ}, 3'b101);

        // ~0x05 + 0 + 1
        start_op(8'h05, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(-1, 1'b0, lat, bc);
        check_result("negate", 8'hFB, 1'b0, 1'b1, 1'b0, lat, bc);

        // AND / OR
        start_op(8'hF0, 8'h3C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done(-1, 1'b0, lat, bc);
        check_result("and", 8'h30, 1'b0, 1'b0, 1'b0, lat, bc);
        start_op(8'h81, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(-1, 1'b0, lat, bc);
        check_result("or", 8'h83, 1'b0, 1'b1, 1'b0, lat, bc);

        // Second start during RUN cycle 3 must be ignored
        start_op(8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(3, 1'b0, lat, bc);
        check_result("ignstart", 8'h10, 1'b0, 1'b0, 1'b0, lat, bc);
        repeat (3) @(negedge clk);
        chk("ignstart.no_rerun", bus.busy, 1'b0);

        // Post-shift requests
`ifdef ALU_SHIFT_EN
        start_op(8'h40, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_done(-1, 1'b0, lat, bc);
        check_result("sra1", 8'hC0, 1'b0, 1'b1, 1'b0, lat, bc);
        start_op(8'h40, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(-1, 1'b0, lat, bc);
        check_result("sll8", 8'h00, 1'b0, 1'b0, 1'b1, lat, bc);
`else
        start_op(8'h40, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_done(-1, 1'b0, lat, bc);
        check_result("sra1", 8'h80, 1'b0, 1'b1, 1'b0, lat, bc);
        start_op(8'h40, 8'h40, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(-1, 1'b0, lat, bc);
        check_result("sll8", 8'h80, 1'b0, 1'b1, 1'b0, lat, bc);
`endif

        // Reset in RUN cycle 4 aborts with all outputs cleared and no done
        start_op(8'h0F, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst.result", bus.result, 8'h00);
        chk("midrst.status", {bus.busy, bus.done, bus.cout, bus.flagN, bus.flagZ}, 5'b00000);
        chk("midrst.drives", {sliceA, sliceB, sliceCarryIn, sliceInvA, sliceEnA, sliceEnB, sliceF0, sliceF1}, 8'h00);
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) done_seen++;
        end
        chk("midrst.no_done", done_seen, 0);

        // Recovery after abort
        start_op(8'hFF, 8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_done(-1, 1'b0, lat, bc);
        check_result("recover", 8'h00, 1'b1, 1'b0, 1'b1, lat, bc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
